// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the RV32I multicycle core. It sequences fetch, decode,
// execute, memory and writeback from the IR opcode, and drives every enable
// and mux select of the datapath. Memory is variable latency: a request is
// held until the memory raises mem_ready. The block also counts retired
// instructions.
//
// Handshake: mem_rden / mem_wren act as "valid". They stay high on every wait
// cycle until mem_ready ("ready") is seen high in the same cycle. That cycle
// completes the transfer. mem_ready has no effect outside FETCH, MEM_READ and
// MEM_WRITE.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   opcode       in   [6:0] instruction opcode from the IR
//   mem_ready    in   memory completes the current read/write this cycle
//   branch_taken in   branch comparison result (sampled in BRANCH)
//   pc_en        out  PC register load
//   ir_en        out  IR load (datapath latches old_pc on the same edge)
//   regfile_wren out  register file write
//   mem_rden     out  memory read request
//   mem_wren     out  memory write request
//   addr_sel     out  memory address: 0=pc_q, 1=ALU output register
//   alu_a_sel    out  [1:0] 0=rs1, 1=old_pc, 2=zero, 3=pc_q
//   alu_b_sel    out  [1:0] 0=rs2, 1=immediate, 2=constant 4
//   alu_op_sel   out  [1:0] 0=add, 1=funct decode, 2=branch compare
//   wb_sel       out  [1:0] 0=ALU, 1=memory data, 2=pc_q
//   pc_src       out  0=ALU result, 1=ALU result with bit0 cleared
//   illegal      out  sticky illegal-opcode flag
//   state_dbg    out  [3:0] current state encoding
//   instret      out  [INSTRET_WIDTH-1:0] retired instruction count
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    input  logic                     mem_ready,
    input  logic                     branch_taken,
    output logic                     pc_en,
    output logic                     ir_en,
    output logic                     regfile_wren,
    output logic                     mem_rden,
    output logic                     mem_wren,
    output logic                     addr_sel,
    output logic [1:0]               alu_a_sel,
    output logic [1:0]               alu_b_sel,
    output logic [1:0]               alu_op_sel,
    output logic [1:0]               wb_sel,
    output logic                     pc_src,
    output logic                     illegal,
    output logic [3:0]               state_dbg,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        DECODE     = 4'd1,
        EXEC_R     = 4'd2,
        EXEC_I     = 4'd3,
        LUI        = 4'd4,
        AUIPC      = 4'd5,
        MEM_ADDR   = 4'd6,
        MEM_READ   = 4'd7,
        LOAD_WB    = 4'd8,
        MEM_WRITE  = 4'd9,
        BRANCH     = 4'd10,
        BRANCH_TGT = 4'd11,
        JAL        = 4'd12,
        JALR       = 4'd13,
        ILLEGAL    = 4'd14
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        pc_en        = 1'b0;
        ir_en        = 1'b0;
        regfile_wren = 1'b0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        addr_sel     = 1'b0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        alu_op_sel   = 2'd0;
        wb_sel       = 2'd0;
        pc_src       = 1'b0;
        illegal      = 1'b0;

        case (state)
            FETCH: begin
                mem_rden = 1'b1;
                if (mem_ready) begin
                    // IR load and PC <= pc_q + 4 share the completing edge.
                    ir_en      = 1'b1;
                    pc_en      = 1'b1;
                    alu_a_sel  = 2'd3;
                    alu_b_sel  = 2'd2;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:              next_state = EXEC_R;
                    OP_I:              next_state = EXEC_I;
                    OP_LOAD, OP_STORE: next_state = MEM_ADDR;
                    OP_BR:             next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    OP_LUI:            next_state = LUI;
                    OP_AUIPC:          next_state = AUIPC;
                    default:           next_state = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                alu_op_sel   = 2'd1;
                regfile_wren = 1'b1;
                next_state   = FETCH;
            end
            EXEC_I: begin
                alu_b_sel    = 2'd1;
                alu_op_sel   = 2'd1;
                regfile_wren = 1'b1;
                next_state   = FETCH;
            end
            LUI: begin
                alu_a_sel    = 2'd2;
                alu_b_sel    = 2'd1;
                regfile_wren = 1'b1;
                next_state   = FETCH;
            end
            AUIPC: begin
                alu_a_sel    = 2'd1;
                alu_b_sel    = 2'd1;
                regfile_wren = 1'b1;
                next_state   = FETCH;
            end
            MEM_ADDR: begin
                alu_b_sel  = 2'd1;
                // IR still holds the opcode, so load vs store is re-decoded here.
                next_state = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_rden = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) next_state = LOAD_WB;
            end
            LOAD_WB: begin
                regfile_wren = 1'b1;
                wb_sel       = 2'd1;
                next_state   = FETCH;
            end
            MEM_WRITE: begin
                mem_wren = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            BRANCH: begin
                alu_op_sel = 2'd2;
                next_state = branch_taken ? BRANCH_TGT : FETCH;
            end
            BRANCH_TGT: begin
                alu_a_sel  = 2'd1;
                alu_b_sel  = 2'd1;
                pc_en      = 1'b1;
                next_state = FETCH;
            end
            JAL, JALR: begin
                // Writeback takes pc_q (already pc+4) before the PC update lands.
                alu_a_sel    = (state == JAL) ? 2'd1 : 2'd0;
                alu_b_sel    = 2'd1;
                pc_en        = 1'b1;
                pc_src       = (state == JALR);
                regfile_wren = 1'b1;
                wb_sel       = 2'd2;
                next_state   = FETCH;
            end
            ILLEGAL: begin
                illegal    = 1'b1;
                next_state = ILLEGAL;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // Reset kills every output without waiting for a clock edge, including
        // the mem_rden that FETCH would otherwise raise.
        if (!rst) begin
            pc_en        = 1'b0;
            ir_en        = 1'b0;
            regfile_wren = 1'b0;
            mem_rden     = 1'b0;
            mem_wren     = 1'b0;
            addr_sel     = 1'b0;
            alu_a_sel    = 2'd0;
            alu_b_sel    = 2'd0;
            alu_op_sel   = 2'd0;
            wb_sel       = 2'd0;
            pc_src       = 1'b0;
            illegal      = 1'b0;
        end
    end

    assign state_dbg = state;

    // One retirement per return to FETCH; ILLEGAL never returns, so it never counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (state != FETCH && next_state == FETCH) begin
            instret <= instret + INSTRET_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int W = 4;

    localparam logic [3:0] S_F   = 4'd0;
    localparam logic [3:0] S_D   = 4'd1;
    localparam logic [3:0] S_ER  = 4'd2;
    localparam logic [3:0] S_EI  = 4'd3;
    localparam logic [3:0] S_LUI = 4'd4;
    localparam logic [3:0] S_AU  = 4'd5;
    localparam logic [3:0] S_MA  = 4'd6;
    localparam logic [3:0] S_MR  = 4'd7;
    localparam logic [3:0] S_LW  = 4'd8;
    localparam logic [3:0] S_MW  = 4'd9;
    localparam logic [3:0] S_BR  = 4'd10;
    localparam logic [3:0] S_BT  = 4'd11;
    localparam logic [3:0] S_JAL = 4'd12;
    localparam logic [3:0] S_JR  = 4'd13;
    localparam logic [3:0] S_IL  = 4'd14;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]   opcode = OP_R;
    logic         mem_ready = 1'b0;
    logic         branch_taken = 1'b0;
    logic         pc_en, ir_en, regfile_wren, mem_rden, mem_wren, addr_sel;
    logic [1:0]   alu_a_sel, alu_b_sel, alu_op_sel, wb_sel;
    logic         pc_src, illegal;
    logic [3:0]   state_dbg;
    logic [W-1:0] instret;

    multicycle_controller #(.INSTRET_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_en(pc_en), .ir_en(ir_en),
        .regfile_wren(regfile_wren), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .addr_sel(addr_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op_sel(alu_op_sel), .wb_sel(wb_sel), .pc_src(pc_src),
        .illegal(illegal), .state_dbg(state_dbg), .instret(instret)
    );

    // Vector layout: state, {pc_en,ir_en,regfile_wren,mem_rden,mem_wren},
    // addr_sel, a, b, op, wb, pc_src, illegal, instret.
    localparam int VW = 24;
    logic [VW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int vec_idx = 0;

    function automatic logic [VW-1:0] ex(input logic [3:0] st, input logic [4:0] stb,
                                         input logic as, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] op,
                                         input logic [1:0] wb, input logic src,
                                         input logic ill, input logic [W-1:0] n);
        return {st, stb, as, a, b, op, wb, src, ill, n};
    endfunction

    function automatic logic [VW-1:0] f_go(input logic [W-1:0] n);
        return ex(S_F, 5'b11010, 1'b0, 2'd3, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, n);
    endfunction
    function automatic logic [VW-1:0] f_wait(input logic [W-1:0] n);
        return ex(S_F, 5'b00010, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, n);
    endfunction
    function automatic logic [VW-1:0] dec(input logic [W-1:0] n);
        return ex(S_D, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, n);
    endfunction
    function automatic logic [VW-1:0] exr(input logic [W-1:0] n);
        return ex(S_ER, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, n);
    endfunction
    function automatic logic [VW-1:0] maddr(input logic [W-1:0] n);
        return ex(S_MA, 5'b00000, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, n);
    endfunction
    function automatic logic [VW-1:0] mwr(input logic [W-1:0] n);
        return ex(S_MW, 5'b00001, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, n);
    endfunction
    function automatic logic [VW-1:0] in_rst();
        return ex(S_F, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, '0);
    endfunction

    // ---------------- driver ----------------
    // Inputs change 2 ns after the rising edge; the expected outputs for that
    // cycle are queued at the same moment and checked on the falling edge.
    task automatic drv(input logic r, input logic [6:0] op, input logic rdy,
                       input logic tk, input logic [VW-1:0] e);
        @(posedge clk);
        #2;
        rst          = r;
        opcode       = op;
        mem_ready    = rdy;
        branch_taken = tk;
        exp_q.push_back(e);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] act, e;
            e   = exp_q.pop_front();
            act = {state_dbg, pc_en, ir_en, regfile_wren, mem_rden, mem_wren,
                   addr_sel, alu_a_sel, alu_b_sel, alu_op_sel, wb_sel,
                   pc_src, illegal, instret};
            checks = checks + 1;
            if (act !== e) begin
                failures = failures + 1;
                $display("FAIL vec%0d: got=%h expected=%h (state got %0d exp %0d)",
                         vec_idx, act, e, act[VW-1 -: 4], e[VW-1 -: 4]);
            end
            vec_idx = vec_idx + 1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Held in reset with mem_ready high: everything must stay quiet.
        drv(1'b0, OP_R, 1'b1, 1'b0, in_rst());
        drv(1'b0, OP_R, 1'b1, 1'b0, in_rst());

        // R-type, no memory wait.
        drv(1'b1, OP_R, 1'b1, 1'b0, f_go(0));
        drv(1'b1, OP_R, 1'b1, 1'b0, dec(0));
        drv(1'b1, OP_R, 1'b1, 1'b0, exr(0));

        // I-type with 3 fetch wait cycles.
        for (int i = 0; i < 3; i++) drv(1'b1, OP_I, 1'b0, 1'b0, f_wait(1));
        drv(1'b1, OP_I, 1'b1, 1'b0, f_go(1));
        drv(1'b1, OP_I, 1'b1, 1'b0, dec(1));
        drv(1'b1, OP_I, 1'b0, 1'b0,
            ex(S_EI, 5'b00100, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1));

        // Load with read latency 2 (mem_ready high in MEM_ADDR is ignored).
        drv(1'b1, OP_LOAD, 1'b1, 1'b0, f_go(2));
        drv(1'b1, OP_LOAD, 1'b1, 1'b0, dec(2));
        drv(1'b1, OP_LOAD, 1'b1, 1'b0, maddr(2));
        drv(1'b1, OP_LOAD, 1'b0, 1'b0,
            ex(S_MR, 5'b00010, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2));
        drv(1'b1, OP_LOAD, 1'b1, 1'b0,
            ex(S_MR, 5'b00010, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2));
        drv(1'b1, OP_LOAD, 1'b1, 1'b0,
            ex(S_LW, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 2));

        // Store, immediate write completion.
        drv(1'b1, OP_STORE, 1'b1, 1'b0, f_go(3));
        drv(1'b1, OP_STORE, 1'b1, 1'b0, dec(3));
        drv(1'b1, OP_STORE, 1'b0, 1'b0, maddr(3));
        drv(1'b1, OP_STORE, 1'b1, 1'b0, mwr(3));

        // Branch taken.
        drv(1'b1, OP_BR, 1'b1, 1'b1, f_go(4));
        drv(1'b1, OP_BR, 1'b1, 1'b1, dec(4));
        drv(1'b1, OP_BR, 1'b1, 1'b1,
            ex(S_BR, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 4));
        drv(1'b1, OP_BR, 1'b1, 1'b0,
            ex(S_BT, 5'b10000, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 4));

        // Branch not taken.
        drv(1'b1, OP_BR, 1'b1, 1'b0, f_go(5));
        drv(1'b1, OP_BR, 1'b1, 1'b0, dec(5));
        drv(1'b1, OP_BR, 1'b1, 1'b0,
            ex(S_BR, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 5));

        // JAL, JALR, LUI, AUIPC.
        drv(1'b1, OP_JAL, 1'b1, 1'b0, f_go(6));
        drv(1'b1, OP_JAL, 1'b1, 1'b0, dec(6));
        drv(1'b1, OP_JAL, 1'b1, 1'b0,
            ex(S_JAL, 5'b10100, 1'b0, 2'd1, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 6));
        drv(1'b1, OP_JALR, 1'b1, 1'b0, f_go(7));
        drv(1'b1, OP_JALR, 1'b1, 1'b0, dec(7));
        drv(1'b1, OP_JALR, 1'b1, 1'b0,
            ex(S_JR, 5'b10100, 1'b0, 2'd0, 2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 7));
        drv(1'b1, OP_LUI, 1'b1, 1'b0, f_go(8));
        drv(1'b1, OP_LUI, 1'b1, 1'b0, dec(8));
        drv(1'b1, OP_LUI, 1'b1, 1'b0,
            ex(S_LUI, 5'b00100, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 8));
        drv(1'b1, OP_AUIPC, 1'b1, 1'b0, f_go(9));
        drv(1'b1, OP_AUIPC, 1'b1, 1'b0, dec(9));
        drv(1'b1, OP_AUIPC, 1'b1, 1'b0,
            ex(S_AU, 5'b00100, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 9));

        // Six more R-types bring the 4-bit counter to 16 -> wraps to 0.
        for (int n = 10; n < 16; n++) begin
            drv(1'b1, OP_R, 1'b1, 1'b0, f_go(W'(n)));
            drv(1'b1, OP_R, 1'b1, 1'b0, dec(W'(n)));
            drv(1'b1, OP_R, 1'b1, 1'b0, exr(W'(n)));
        end
        drv(1'b1, OP_R, 1'b1, 1'b0, f_go(0));
        drv(1'b1, OP_R, 1'b1, 1'b0, dec(0));
        drv(1'b1, OP_R, 1'b1, 1'b0, exr(0));

        // Store stalled in MEM_WRITE, then reset lands mid-cycle.
        drv(1'b1, OP_STORE, 1'b1, 1'b0, f_go(1));
        drv(1'b1, OP_STORE, 1'b1, 1'b0, dec(1));
        drv(1'b1, OP_STORE, 1'b0, 1'b0, maddr(1));
        drv(1'b1, OP_STORE, 1'b0, 1'b0, mwr(1));
        drv(1'b0, OP_STORE, 1'b0, 1'b0, in_rst());
        drv(1'b0, OP_STORE, 1'b1, 1'b0, in_rst());
        drv(1'b1, OP_BAD, 1'b0, 1'b0, f_wait(0));
        drv(1'b1, OP_BAD, 1'b1, 1'b0, f_go(0));
        drv(1'b1, OP_BAD, 1'b1, 1'b0, dec(0));

        // Illegal opcode: terminal, quiet, counter frozen, inputs toggling.
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, (i % 2 == 0) ? OP_R : OP_BAD, 1'(i % 2), 1'(i % 3 == 0),
                ex(S_IL, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 0));
        end
        drv(1'b0, OP_R, 1'b1, 1'b0, in_rst());
        drv(1'b1, OP_R, 1'b1, 1'b0, f_go(0));
        drv(1'b1, OP_R, 1'b1, 1'b0, dec(0));

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the RV32I multicycle core. It consumes the 7-bit opcode decoded by the datapath from the instruction register and sequences fetch, decode, execute, memory and writeback. It drives every enable and mux select of the datapath and handles variable-latency memory through a ready handshake. It also keeps a retired-instruction counter.

Parameters:
INSTRET_WIDTH, 32, width of the retired-instruction counter (wraps modulo 2^INSTRET_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
opcode  input  7  instruction[6:0] from datapath (rv32i_opcode_t encoding)
mem_ready  input  1  memory completes current read/write this cycle
branch_taken  input  1  datapath branch comparison result (valid in BRANCH state)
pc_en  output  1  PC register load
ir_en  output  1  IR load; the datapath latches old_pc on the same edge
regfile_wren  output  1  register file write
mem_rden  output  1  memory read request
mem_wren  output  1  memory write request
addr_sel  output  1  memory address: 0=pc_q, 1=ALU output register
alu_a_sel  output  2  0=rs1, 1=old_pc, 2=zero, 3=pc_q
alu_b_sel  output  2  0=rs2, 1=immediate, 2=constant 4
alu_op_sel  output  2  0=add, 1=funct3/funct7 decode, 2=branch compare
wb_sel  output  2  0=ALU, 1=memory read data, 2=pc_q
pc_src  output  1  0=ALU result, 1=ALU result with bit0 cleared (JALR)
illegal  output  1  sticky illegal-opcode flag
state_dbg  output  4  current state encoding
instret  output  INSTRET_WIDTH  retired instruction count

Behaviour:
- Moore outputs decode from state only, except the handshake-qualified strobes noted below. Any output not listed for a state is 0.
- While rst=0: state=FETCH, instret=0, illegal=0, and all strobes (pc_en, ir_en, regfile_wren, mem_rden, mem_wren) are forced to 0 combinationally. The selects are 0.
- FETCH: mem_rden=1, addr_sel=0. Remain in FETCH until mem_ready=1. In the mem_ready cycle: ir_en=1, pc_en=1, alu_a_sel=3, alu_b_sel=2, alu_op_sel=0, pc_src=0, and the next state is DECODE.
- DECODE: 1 cycle, no strobes. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 and 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> ILLEGAL
- EXEC_R: a=0, b=0, op=1, regfile_wren=1, wb_sel=0 -> FETCH.
- EXEC_I: a=0, b=1, op=1, regfile_wren=1, wb_sel=0 -> FETCH.
- LUI: a=2, b=1, op=0, regfile_wren=1 -> FETCH.
- AUIPC: a=1, b=1, op=0, regfile_wren=1 -> FETCH.
- MEM_ADDR: a=0, b=1, op=0; the datapath registers the ALU output. Next state is MEM_READ for a load or MEM_WRITE for a store. The opcode is held stable by the IR.
- MEM_READ: mem_rden=1, addr_sel=1. Wait for mem_ready, then go to LOAD_WB.
- LOAD_WB: regfile_wren=1, wb_sel=1 -> FETCH.
- MEM_WRITE: mem_wren=1, addr_sel=1. Hold until mem_ready, then go to FETCH.
- BRANCH: a=0, b=0, op=2. If branch_taken=1, go to BRANCH_TGT; otherwise go to FETCH (retire).
- BRANCH_TGT: a=1, b=1, op=0, pc_en=1, pc_src=0 -> FETCH.
- JAL: a=1, b=1, op=0, pc_en=1, pc_src=0, regfile_wren=1, wb_sel=2 -> FETCH. The write samples pc_q before the update.
- JALR: same as JAL but a=0 and pc_src=1.
- ILLEGAL: illegal=1 and all strobes 0. Terminal; exit only through rst.
- Minimum cycles per instruction:
  - ALU, LUI, AUIPC, JAL, JALR, not-taken branch: 3
  - taken branch and store: 4
  - load: 5
  - plus extra memory wait cycles.
- instret increments by 1 on every transition into FETCH from a non-FETCH state, and wraps. It never increments for ILLEGAL.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE. mem_rden and mem_wren stay asserted for every wait cycle.
- Reset asserted mid-operation, including during a memory request: strobes drop in the same cycle with no clock edge needed. After release the FSM restarts in FETCH.

Test Plan:
- Release rst, opcode=0110011, mem_ready=1 -> cycle0 FETCH with pc_en=ir_en=1; cycle1 DECODE; cycle2 regfile_wren=1, wb_sel=0; instret=1 after cycle2.
- FETCH with mem_ready low for 3 cycles -> mem_rden=1 for 4 cycles, ir_en and pc_en pulse only in the 4th, then DECODE.
- opcode=0000011, MEM_READ latency 2 -> states FETCH, DECODE, MEM_ADDR, MEM_READ x2, LOAD_WB; exactly one regfile_wren pulse with wb_sel=1, addr_sel=1 throughout MEM_READ.
- opcode=1100011 with branch_taken=1 vs 0 -> taken: pc_en in BRANCH_TGT, 4 cycles; not taken: no pc_en after FETCH, 3 cycles; instret +1 in both cases.
- opcode=0000000 -> illegal=1 from the cycle after DECODE, stays 1 for 20 cycles with no strobes and instret frozen; rst=0 clears it and state returns to FETCH.
- rst=0 asserted mid-MEM_WRITE (store, mem_ready low) -> mem_wren=0 immediately with no clock edge; after release, FETCH with mem_rden=1. With INSTRET_WIDTH=4, 16 retired instructions -> instret=0.
